// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch/decode handshake bundle for if_id_queue.
//   in_valid/in_ready/in_pc/in_instr : fetch-side offer and acceptance
//   out_valid/out_ready/out_pc/out_instr : decode-side head entry and consume
//   flush : redirect from EX, discards all queued entries
//   count : current queue occupancy
// modport slave is the queue's view; modport master is the driver/consumer view.
interface if_id_queue_if #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_pc;
    logic [WIDTH-1:0]         in_instr;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_pc;
    logic [WIDTH-1:0]         out_instr;
    logic                     flush;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready, flush,
        output in_ready, out_valid, out_pc, out_instr, count
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue: in-order decoupling queue between fetch and decode.
// Holds up to DEPTH {pc, instr} entries in a circular buffer and presents the
// oldest to decode under valid/ready. flush empties the queue in one cycle and
// masks out_valid in the flush cycle itself. When nothing is valid, decode sees
// out_pc = 0 and out_instr = NOP.
//
// Ports:
//   clk   : pipeline clock, rising edge
//   reset : asynchronous, active-high; clears pointers and count
//   q     : if_id_queue_if.slave (fetch side in_*, decode side out_*, flush, count)
//
// Optional feature: define IF_QUEUE_BYPASS_EN to forward in_* straight to out_*
// when the queue is empty, giving zero-cycle latency.
module if_id_queue #(
    parameter int unsigned    DEPTH = 2,
    parameter int unsigned    WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    if_id_queue_if.slave  q
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic empty;
    logic full;
    logic bypass;
    logic out_valid_int;
    logic wr_en;
    logic rd_en;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));
    end

`ifdef IF_QUEUE_BYPASS_EN
    // Empty queue with a live offer: the incoming entry is the head.
    always_comb begin
        bypass = empty & q.in_valid & ~q.flush;
    end
`else
    always_comb begin
        bypass = 1'b0;
    end
`endif

    always_comb begin
        out_valid_int = (~empty | bypass) & ~q.flush;
        // A bypassed entry consumed in the same cycle is never stored.
        wr_en = q.in_valid & ~full & ~q.flush & ~(bypass & q.out_ready);
        // A bypassed pop consumes the incoming entry, not storage.
        rd_en = out_valid_int & q.out_ready & ~bypass;
    end

    // Next-state for pointers and occupancy; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count_d = count_q + 1'b1;
            end else if (!wr_en && rd_en) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; pointers/count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr_q]    <= q.in_pc;
            instr_mem[wr_ptr_q] <= q.in_instr;
        end
    end

    always_comb begin
        q.in_ready  = ~full;
        q.count     = count_q;
        q.out_valid = out_valid_int;
        q.out_pc    = '0;
        q.out_instr = NOP;
        if (out_valid_int) begin
            if (bypass) begin
                q.out_pc    = q.in_pc;
                q.out_instr = q.in_instr;
            end else begin
                q.out_pc    = pc_mem[rd_ptr_q];
                q.out_instr = instr_mem[rd_ptr_q];
            end
        end
    end

endmodule
